// File: rtl/msnw_pkg.sv
// Shared MSNW definitions: default packet width, packet type and parity helper.
package msnw_pkg;

    localparam int unsigned MSNW_PKT_WIDTH_DFLT = 64;

    typedef logic [MSNW_PKT_WIDTH_DFLT-1:0] msnw_pkt_t;

    // Even parity over the whole packet, parity bit included.
    function automatic logic msnw_parity_ok(input msnw_pkt_t pkt);
        return ~(^pkt);
    endfunction

endpackage

// File: rtl/msnw_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module msnw_sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata_c,
    output logic                       full_c,
    output logic                       empty_c,
    output logic [$clog2(DEPTH):0]     level,
    output logic [$clog2(DEPTH):0]     level_nxt_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok_c;
    logic             pop_ok_c;

    always_comb begin
        full_c      = (level == LVL_W'(DEPTH));
        empty_c     = (level == '0);
        pop_ok_c    = pop & ~empty_c;
        push_ok_c   = push & (~full_c | pop_ok_c);
        level_nxt_c = level + LVL_W'(push_ok_c) - LVL_W'(pop_ok_c);
        rdata_c     = mem[rd_ptr];
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level_nxt_c;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok_c) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/msnw_rx_slave.sv
// MSNW slave receive endpoint: input stage, parity check, packet FIFO,
// xoff back-pressure and saturating error counters.
module msnw_rx_slave
    import msnw_pkg::*;
#(
    parameter int unsigned MSNW_PKT_WIDTH = MSNW_PKT_WIDTH_DFLT,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned XOFF_SKID      = 2,
    parameter int unsigned ERR_CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rstb,
    input  logic [MSNW_PKT_WIDTH-1:0]     msnw_pkt,
    input  logic                          valid,
    input  logic                          parity_en,
    output logic                          xoff,
    output logic                          parity_error,
    output logic [MSNW_PKT_WIDTH-1:0]     error_pkt,
    output logic [MSNW_PKT_WIDTH-1:0]     out_pkt,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic [ERR_CNT_W-1:0]          perr_cnt,
    output logic [ERR_CNT_W-1:0]          ovf_cnt
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SUM_W = LVL_W + 1;
    localparam int unsigned XOFF_THR = FIFO_DEPTH - XOFF_SKID;

    logic                      stage_v;
    logic [MSNW_PKT_WIDTH-1:0] stage_pkt;
    logic                      stage_pe;
    logic                      parity_odd_c;
    logic                      bad_c;
    logic                      good_c;
    logic                      pop_c;
    logic                      push_c;
    logic                      drop_c;
    logic                      full_c;
    logic                      empty_c;
    logic [LVL_W-1:0]          level_nxt_c;
    logic [SUM_W-1:0]          fill_nxt_c;

    // Unconditional capture: the master is not handshaked, only throttled by xoff.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            stage_v   <= 1'b0;
            stage_pkt <= '0;
            stage_pe  <= 1'b0;
        end else begin
            stage_v   <= valid;
            stage_pkt <= msnw_pkt;
            stage_pe  <= parity_en;
        end
    end

    generate
        if (MSNW_PKT_WIDTH == MSNW_PKT_WIDTH_DFLT) begin : g_pkg_parity
            assign parity_odd_c = ~msnw_parity_ok(msnw_pkt_t'(stage_pkt));
        end else begin : g_raw_parity
            assign parity_odd_c = ^stage_pkt;
        end
    endgenerate

    always_comb begin
        bad_c      = stage_v & stage_pe & parity_odd_c;
        good_c     = stage_v & ~bad_c;
        pop_c      = out_valid & out_ready;
        push_c     = good_c & (~full_c | pop_c);
        drop_c     = good_c & full_c & ~pop_c;
        out_valid  = ~empty_c;
        fill_nxt_c = SUM_W'(level_nxt_c) + SUM_W'(valid);
    end

    msnw_sync_fifo #(
        .WIDTH (MSNW_PKT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rstb        (rstb),
        .push        (push_c),
        .wdata       (stage_pkt),
        .pop         (pop_c),
        .rdata_c     (out_pkt),
        .full_c      (full_c),
        .empty_c     (empty_c),
        .level       (level),
        .level_nxt_c (level_nxt_c)
    );

    // Status pulses, error capture and saturating counters.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            xoff         <= 1'b0;
            parity_error <= 1'b0;
            error_pkt    <= '0;
            overflow     <= 1'b0;
            perr_cnt     <= '0;
            ovf_cnt      <= '0;
        end else begin
            xoff         <= (fill_nxt_c >= SUM_W'(XOFF_THR));
            parity_error <= bad_c;
            overflow     <= drop_c;
            if (bad_c) error_pkt <= stage_pkt;
            if (bad_c && (perr_cnt != '1)) perr_cnt <= perr_cnt + ERR_CNT_W'(1);
            if (drop_c && (ovf_cnt != '1)) ovf_cnt <= ovf_cnt + ERR_CNT_W'(1);
        end
    end

endmodule

// File: doc/msnw_rx_slave.md
Name: msnw_rx_slave

Overview:
- Slave-side endpoint of the message network (MSNW) link. It accepts packets from an MSNW master, checks optional parity, buffers good packets in a FIFO, and drives xoff back-pressure.
- It presents buffered packets to the downstream MSNW-to-AXI logic on a valid/ready port.
- It reports parity errors through parity_error / error_pkt, and reports overflow drops.

Parameters:
- MSNW_PKT_WIDTH, 64: packet width in bits. Bit MSNW_PKT_WIDTH-1 is the parity bit when parity_en=1.
- FIFO_DEPTH, 8: buffer entries. Power of 2, ≥4.
- XOFF_SKID, 2: free entries reserved for packets already in flight when xoff asserts. Must be less than FIFO_DEPTH.
- ERR_CNT_W, 16: width of the saturating error counters.

Ports:
- clk  in  1  clock; all logic on posedge.
- rstb  in  1  asynchronous active-low reset.
- msnw_pkt  in  MSNW_PKT_WIDTH  incoming packet.
- valid  in  1  msnw_pkt valid this cycle.
- parity_en  in  1  packet carries even parity in its MSB.
- xoff  out  1  back-pressure to the master; registered.
- parity_error  out  1  one-cycle pulse per parity-failed packet.
- error_pkt  out  MSNW_PKT_WIDTH  last parity-failed packet, held.
- out_pkt  out  MSNW_PKT_WIDTH  head-of-FIFO packet.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  downstream accepts out_pkt.
- overflow  out  1  one-cycle pulse when a good packet is dropped because the FIFO is full.
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- perr_cnt  out  ERR_CNT_W  saturating parity-error count.
- ovf_cnt  out  ERR_CNT_W  saturating overflow-drop count.

Behaviour:
- Reset (rstb=0, asynchronous):
  - All outputs are 0: xoff, parity_error, error_pkt, out_valid, overflow, level, perr_cnt, ovf_cnt.
  - The FIFO is emptied and the input stage is invalidated.
  - Reset mid-packet discards the packet in the stage and all FIFO contents.
- Input stage: on each posedge, register valid, msnw_pkt and parity_en into stage_v, stage_pkt and stage_pe. No handshake: a packet is taken whenever valid=1, regardless of xoff.
- Parity check:
  - bad = stage_v & stage_pe & (XOR-reduce of stage_pkt != 0), i.e. even parity over all bits.
  - Parity is checked only when stage_pe=1. The parity bit is stored in the FIFO unmodified.
- Stage resolution, one edge after the stage loads:
  - If bad: do not write. Pulse parity_error for 1 cycle, error_pkt <= stage_pkt, perr_cnt += 1 (saturates at all-ones).
  - If good and the FIFO is not full, or the FIFO is full while a pop occurs in the same cycle: write.
  - If good and the FIFO is full with no pop: drop. Pulse overflow for 1 cycle, ovf_cnt += 1 (saturates).
- FIFO behaviour:
  - First-word-fall-through: out_pkt is valid whenever out_valid=1.
  - Pop when out_valid & out_ready.
  - Simultaneous push and pop keeps level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - No write-to-read bypass when empty.
- Latency: valid sampled at edge N → stage at N → written at N+1 → out_valid=1 after edge N+1.
- xoff:
  - xoff <= (level_next + stage_v_next) >= FIFO_DEPTH - XOFF_SKID, evaluated every edge.
  - Deassertion uses the same comparison; there is no hysteresis.
  - A master honouring xoff with up to XOFF_SKID cycles of reaction latency never causes an overflow.
- Back-to-back bad packets pulse parity_error on consecutive cycles; error_pkt tracks the latest one.
- Counters do not wrap; they clear only on reset.

Decomposition:
- Package msnw_pkg:
  - MSNW_PKT_WIDTH default constant.
  - msnw_pkt_t typedef (logic [MSNW_PKT_WIDTH-1:0]).
  - msnw_parity_ok function.
- Sub-module msnw_sync_fifo (parameters WIDTH, DEPTH; FWFT, push/pop/full/empty/level). It is reusable by the master-side block.
- The top contains the input stage, parity check, xoff and counters.

Test Plan:
- Reset with level=5 mid-stream → all outputs 0 immediately and stay 0 after rstb=1.
- Basic: send 0x0000_0000_0000_00A5 with parity_en=0 at cycle 0, out_ready=1 → out_valid=1 with out_pkt=0x...00A5 after edge 1; out_valid deasserts next cycle.
- Parity: send 0x0000_0000_0000_0001 with parity_en=1 (odd) → parity_error pulse 1 cycle, error_pkt=0x...0001, perr_cnt=1, level stays 0. Send 0x8000_0000_0000_0001 with parity_en=1 → stored, no error.
- xoff, DEPTH=8, SKID=2, out_ready=0: stream 6 packets → xoff=1 once level+stage reaches 6. Send 2 more → level=8, no overflow. Send 1 more → overflow pulse, ovf_cnt=1, level=8.
- Full with simultaneous pop: level=8, valid packet arrives, out_ready=1 on its write cycle → written, no overflow, level stays 8. Drain to level 5 → xoff=0.
- Saturation: force ERR_CNT_W=4 and inject 20 parity errors → perr_cnt=15 and holds.
